rom_loader: RTL and testbench

Boot-time sequencer that walks the combinational program ROM byte by byte, packs bytes little-endian into 32-bit words, and writes each word into instruction memory over a valid/ready handshake. It sits between the ROM and the core's memory write port. It holds the CPU in reset until the whole image is loaded, then releases it.

---
 rtl/rom_loader_pkg.sv | 17 +
 rtl/rom_loader_byte_packer.sv | 39 +++
 rtl/rom_loader.sv | 143 ++++++++++++++
 tb/tb_rom_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader.
//   state_t    : loader FSM states
//   WORD_BYTES : bytes packed into one memory word
//   ADDR_W     : width of ROM and memory byte addresses
package rom_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Little-endian byte packer: writes one byte into a selected lane of a
// 32-bit buffer. A clear zeroes the whole buffer and wins over a write, so
// lanes that are never written in a partial word stay zero.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr_i      : zero the buffer
//   we_i       : write byte_i into lane lane_i
//   lane_i     : lane select (0 = bits 7:0)
//   byte_i     : byte to store
//   word_o     : packed buffer contents
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [31:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (clr_i) begin
      buf_d = '0;
    end else if (we_i) begin
      buf_d[8*lane_i +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else        buf_q <= buf_d;
  end

  assign word_o = buf_q;

endmodule

// File: rtl/rom_loader.sv
// Boot-time sequencer: walks a combinational ROM one byte per cycle, packs
// bytes little-endian into 32-bit words and writes each word to instruction
// memory. The CPU is held in reset until the whole image is written.
// Handshake: a write is offered while mem_we=1; mem_addr/mem_wdata stay
// stable until the cycle where mem_we and mem_ready are both high, and the
// write is accepted on that clock edge.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : level, begins a load from IDLE or DONE
//   rom_address       : byte address to ROM
//   rom_byte          : ROM data (combinational from rom_address)
//   rom_done          : rom_address is the last image byte
//   mem_addr          : word-aligned byte address of the write
//   mem_wdata         : packed word
//   mem_we, mem_ready : write valid / accept
//   busy              : FETCH or WRITE
//   load_done         : in DONE
//   cpu_rst_n         : CPU reset release (equals load_done)
//   word_count        : words accepted since last start
//   overrun           : sticky, MAX_BYTES reached without rom_done
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0,
  parameter int unsigned       MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_byte,
  input  logic              rom_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              load_done,
  output logic              cpu_rst_n,
  output logic [15:0]       word_count,
  output logic              overrun
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              overrun_q, overrun_d;
  logic              last_q, last_d;
  logic              pack_clr, pack_we;
  logic              guard_hit;

  // The last byte the overrun guard allows; reaching it ends the image.
  assign guard_hit = (rom_addr_q == ADDR_W'(MAX_BYTES - 1));

  byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pack_clr),
    .we_i   (pack_we),
    .lane_i (byte_idx_q),
    .byte_i (rom_byte),
    .word_o (mem_wdata)
  );

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    mem_addr_d   = mem_addr_q;
    byte_idx_d   = byte_idx_q;
    word_count_d = word_count_q;
    overrun_d    = overrun_q;
    last_d       = last_q;
    pack_clr     = 1'b0;
    pack_we      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = FETCH;
          rom_addr_d   = '0;
          mem_addr_d   = MEM_BASE;
          byte_idx_d   = 2'd0;
          word_count_d = 16'd0;
          overrun_d    = 1'b0;
          last_d       = 1'b0;
          pack_clr     = 1'b1;
        end
      end
      FETCH: begin
        // ROM data is sampled on the same edge the address advances.
        pack_we    = 1'b1;
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        byte_idx_d = byte_idx_q + 2'd1;
        last_d     = rom_done | guard_hit;
        if (guard_hit && !rom_done) overrun_d = 1'b1;
        if (byte_idx_q == 2'd3 || rom_done || guard_hit) state_d = WRITE;
      end
      WRITE: begin
        if (mem_ready) begin
          word_count_d = word_count_q + 16'd1;
          mem_addr_d   = mem_addr_q + ADDR_W'(WORD_BYTES);
          byte_idx_d   = 2'd0;
          pack_clr     = 1'b1;
          state_d      = last_q ? DONE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      mem_addr_q   <= MEM_BASE;
      byte_idx_q   <= 2'd0;
      word_count_q <= 16'd0;
      overrun_q    <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      mem_addr_q   <= mem_addr_d;
      byte_idx_q   <= byte_idx_d;
      word_count_q <= word_count_d;
      overrun_q    <= overrun_d;
      last_q       <= last_d;
    end
  end

  // Status outputs decode the state register directly, so an async reset
  // drops them without waiting for a clock.
  assign rom_address = rom_addr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = (state_q == WRITE);
  assign busy        = (state_q == FETCH) || (state_q == WRITE);
  assign load_done   = (state_q == DONE);
  assign cpu_rst_n   = load_done;
  assign word_count  = word_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (default guard, BASE) ----------------
  logic        start;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_ready;
  logic        busy, load_done, cpu_rst_n;
  logic [15:0] word_count;
  logic        overrun;

  logic [7:0] rom_mem [0:255];
  int         rom_len;

  assign rom_byte = (rom_address < 32'(rom_len)) ? rom_mem[rom_address[7:0]] : 8'h00;
  assign rom_done = (rom_address == 32'(rom_len - 1));

  rom_loader #(.MEM_BASE(BASE), .MAX_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .load_done(load_done), .cpu_rst_n(cpu_rst_n),
    .word_count(word_count), .overrun(overrun)
  );

  // ---------------- DUT 2 (MAX_BYTES=8, rom_done never set) ----------------
  logic        start2;
  logic [31:0] rom_address2, mem_addr2, mem_wdata2;
  logic [7:0]  rom_byte2;
  logic        mem_we2, busy2, load_done2, cpu_rst_n2, overrun2;
  logic [15:0] word_count2;

  assign rom_byte2 = rom_address2[7:0] + 8'hA0;

  rom_loader #(.MEM_BASE(32'h0), .MAX_BYTES(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .rom_address(rom_address2), .rom_byte(rom_byte2), .rom_done(1'b0),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_ready(1'b1),
    .busy(busy2), .load_done(load_done2), .cpu_rst_n(cpu_rst_n2),
    .word_count(word_count2), .overrun(overrun2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_q2[$];
  logic [31:0] got_addr [0:31];
  logic [31:0] got_data [0:31];
  int acc_cnt     = 0;
  int stall_word  = -1;
  int stall_left  = 0;
  bit stalling    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Decides mem_ready for the coming edge and scores accepted writes.
  always @(negedge clk) begin
    if (stall_left > 0 && acc_cnt == stall_word && (mem_we || stalling)) begin
      stalling = 1;
      check("stall_mem_we", {63'd0, mem_we}, 64'd1);
      if (exp_q.size() > 0) check("stall_hold", {mem_addr, mem_wdata}, exp_q[0]);
      mem_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      stalling  = 0;
      mem_ready = 1'b1;
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL write_unexpected: got 0x%0h@0x%0h expected no write", mem_wdata, mem_addr);
        end else begin
          check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
        if (acc_cnt < 32) begin
          got_addr[acc_cnt] = mem_addr;
          got_data[acc_cnt] = mem_wdata;
        end
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we2) begin
      if (exp_q2.size() == 0) begin
        n_checks++;
        $display("FAIL write2_unexpected: got 0x%0h@0x%0h expected no write", mem_wdata2, mem_addr2);
      end else begin
        check("write2", {mem_addr2, mem_wdata2}, exp_q2.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_image(input int len, input int pat);
    for (int i = 0; i < 256; i++) rom_mem[i] = (pat == 1) ? 8'(i + 1) : 8'h00;
    if (pat == 0) begin
      rom_mem[0] = 8'd57; rom_mem[4] = 8'd19; rom_mem[8] = 8'd14;
      rom_mem[9] = 8'd1;  rom_mem[14] = 8'd1;
    end
    rom_len = len;
  endtask

  task automatic push_expected(input int len);
    logic [31:0] d;
    for (int w = 0; w < (len + 3) / 4; w++) begin
      d = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < len) d[8*b +: 8] = rom_mem[4*w + b];
      exp_q.push_back({BASE + 32'(4 * w), d});
    end
  endtask

  // Pulses start; returns edges from the one leaving IDLE/DONE until load_done.
  task automatic run_load(input int len, input int pat, input int sw, input int sc, output int lat);
    load_image(len, pat);
    push_expected(len);
    acc_cnt = 0; stall_word = sw; stall_left = sc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_cpu_rst", {63'd0, cpu_rst_n}, 64'd0);
    check("start_wc_clear", {48'd0, word_count}, 64'd0);
    lat = 0;
    while (!load_done && lat < 3000) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  typedef struct {
    int len; int pat; int stall_word; int stall_cycles; int exp_words; int exp_lat;
  } vec_t;

  vec_t vecs[5];
  int lat;

  initial begin
    vecs[0] = '{54, 0, -1, 0, 14, 68};
    vecs[1] = '{54, 0,  5, 3, 14, 71};
    vecs[2] = '{ 5, 1, -1, 0,  2,  7};
    vecs[3] = '{ 1, 1, -1, 0,  1,  2};
    vecs[4] = '{ 9, 1, -1, 0,  3, 12};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mem_ready = 1'b1;
    load_image(54, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_address", {32'd0, rom_address}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, {32'd0, BASE});
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
    check("rst_word_count", {48'd0, word_count}, 64'd0);
    check("rst_busy_done_ovr", {61'd0, busy, load_done, overrun}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Overrun guard on the 8-byte instance, then restart from DONE.
    for (int r = 0; r < 2; r++) begin
      exp_q2.push_back({32'h0, 32'hA3A2A1A0});
      exp_q2.push_back({32'h4, 32'hA7A6A5A4});
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      check("ovr_start_cpu_rst", {63'd0, cpu_rst_n2}, 64'd0);
      check("ovr_start_cleared", {63'd0, overrun2}, 64'd0);
      lat = 0;
      while (!load_done2 && lat < 3000) begin
        @(posedge clk); #1 lat++;
      end
      check("ovr_latency", 64'(lat), 64'd10);
      check("ovr_overrun", {63'd0, overrun2}, 64'd1);
      check("ovr_word_count", {48'd0, word_count2}, 64'd2);
      check("ovr_cpu_rst_n", {63'd0, cpu_rst_n2}, 64'd1);
      check("ovr_queue_empty", 64'(exp_q2.size()), 64'd0);
    end

    // Table-driven loads on the main instance.
    for (int v = 0; v < 5; v++) begin
      run_load(vecs[v].len, vecs[v].pat, vecs[v].stall_word, vecs[v].stall_cycles, lat);
      check("latency", 64'(lat), 64'(vecs[v].exp_lat));
      check("load_done", {63'd0, load_done}, 64'd1);
      check("cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("word_count", {48'd0, word_count}, 64'(vecs[v].exp_words));
      check("words_seen", 64'(acc_cnt), 64'(vecs[v].exp_words));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("end_mem_addr", {32'd0, mem_addr}, {32'd0, BASE + 32'(4 * vecs[v].exp_words)});
      check("no_overrun", {63'd0, overrun}, 64'd0);
      if (v == 0) begin
        check("w0_data", {32'd0, got_data[0]}, 64'h0000_0039);
        check("w1_data", {32'd0, got_data[1]}, 64'h0000_0013);
        check("w2_data", {32'd0, got_data[2]}, 64'h0000_010E);
        check("w3_data", {32'd0, got_data[3]}, 64'h0001_0000);
        check("w13_data", {32'd0, got_data[13]}, 64'h0000_0000);
        check("w13_addr", {32'd0, got_addr[13]}, {32'd0, BASE + 32'h34});
      end
      if (v == 2) begin
        check("b5_w0", {32'd0, got_data[0]}, 64'h0403_0201);
        check("b5_w1", {32'd0, got_data[1]}, 64'h0000_0005);
      end
      if (v == 3) check("b1_w0", {32'd0, got_data[0]}, 64'h0000_0001);
    end

    // Async reset during the write of word 7.
    load_image(54, 0);
    push_expected(54);
    acc_cnt = 0; stall_word = -1; stall_left = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (!(mem_we && acc_cnt == 7) && lat < 500) begin
      @(posedge clk); #1 lat++;
    end
    check("reach_word7", {62'd0, mem_we, acc_cnt == 7}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_we", {63'd0, mem_we}, 64'd0);
    check("arst_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_word_count", {48'd0, word_count}, 64'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {61'd0, busy, load_done, mem_we}, 64'd0);
    check("post_rst_rom_addr", {32'd0, rom_address}, 64'd0);
    check("post_rst_wc", {48'd0, word_count}, 64'd0);
    check("post_rst_no_write", 64'(acc_cnt), 64'd7);
    run_load(54, 0, -1, 0, lat);
    check("reload_latency", 64'(lat), 64'd68);
    check("reload_word_count", {48'd0, word_count}, 64'd14);
    check("reload_w0", {32'd0, got_data[0]}, 64'h0000_0039);
    check("reload_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
